// File: rtl/pulse_duty_meter.sv
// Measures the high and low phase lengths of an asynchronous timer pulse in clk cycles
// and publishes each complete period through a valid/ready handshake.
module pulse_duty_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             count_on_rst,
    input  logic             pulse_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] on_time,
    output logic [CNT_W-1:0] off_time,
    output logic [7:0]       meas_count,
    output logic             overrun,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_WAIT_RISE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0]       off_cnt_q, off_cnt_d;
    logic                   pub_q;
    logic [CNT_W-1:0]       pub_on_q, pub_off_q;

    logic s_lvl, rise, fall, primed;
    logic publish_c, timeout_c, clear_stuck_c;

    assign s_lvl  = sync_q[SYNC_STAGES-1];
    assign rise   = s_lvl & ~prev_q;
    assign fall   = ~s_lvl & prev_q;
    // The chain holds reset zeros until it has been refilled from pulse_in; a level
    // seen before that is not real and must not release WAIT_LOW.
    assign primed = prime_q[SYNC_STAGES-1];

    // Synchronizer, edge-detect history and priming chain
    always_ff @(posedge clk or posedge count_on_rst) begin
        if (count_on_rst) begin
            sync_q  <= '0;
            prime_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= s_lvl;
        end
    end

    // FSM and phase counters
    always_ff @(posedge clk or posedge count_on_rst) begin
        if (count_on_rst) begin
            state_q   <= ST_WAIT_LOW;
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            on_cnt_q  <= on_cnt_d;
            off_cnt_q <= off_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        on_cnt_d      = on_cnt_q;
        off_cnt_d     = off_cnt_q;
        publish_c     = 1'b0;
        timeout_c     = 1'b0;
        clear_stuck_c = 1'b0;
        case (state_q)
            ST_WAIT_LOW: begin
                if (primed && !s_lvl) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    on_cnt_d      = ONE_C;
                    off_cnt_d     = '0;
                    clear_stuck_c = 1'b1;
                    state_d       = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    off_cnt_d = ONE_C;
                    state_d   = ST_LOW;
                end else if (s_lvl) begin
                    if (on_cnt_q >= TIMEOUT_C) timeout_c = 1'b1;
                    else                       on_cnt_d  = on_cnt_q + ONE_C;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    publish_c = 1'b1;
                    on_cnt_d  = ONE_C;
                    off_cnt_d = '0;
                    state_d   = ST_HIGH;
                end else if (!s_lvl) begin
                    if (off_cnt_q >= TIMEOUT_C) timeout_c = 1'b1;
                    else                        off_cnt_d = off_cnt_q + ONE_C;
                end
            end
            default: state_d = ST_WAIT_LOW;
        endcase
        // A stuck phase abandons the period; only a fresh low-then-rise restarts it
        if (timeout_c) begin
            on_cnt_d  = '0;
            off_cnt_d = '0;
            state_d   = s_lvl ? ST_WAIT_LOW : ST_WAIT_RISE;
        end
    end

    // Snapshot of the finished period, presented to the output stage next cycle
    always_ff @(posedge clk or posedge count_on_rst) begin
        if (count_on_rst) begin
            pub_q     <= 1'b0;
            pub_on_q  <= '0;
            pub_off_q <= '0;
        end else begin
            pub_q <= publish_c;
            if (publish_c) begin
                pub_on_q  <= on_cnt_q;
                pub_off_q <= off_cnt_q;
            end
        end
    end

    // Stuck flag: set on timeout, cleared by the next accepted rise
    always_ff @(posedge clk or posedge count_on_rst) begin
        if (count_on_rst) begin
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (timeout_c) begin
            stuck       <= 1'b1;
            stuck_level <= s_lvl;
        end else if (clear_stuck_c) begin
            stuck <= 1'b0;
        end
    end

    // Output stage and handshake; a publish wins over an accept on the same edge
    always_ff @(posedge clk or posedge count_on_rst) begin
        if (count_on_rst) begin
            meas_valid <= 1'b0;
            on_time    <= '0;
            off_time   <= '0;
            meas_count <= '0;
            overrun    <= 1'b0;
        end else if (pub_q) begin
            meas_valid <= 1'b1;
            on_time    <= pub_on_q;
            off_time   <= pub_off_q;
            meas_count <= meas_count + 8'd1;
            if (meas_valid && !meas_ready) overrun <= 1'b1;
        end else if (meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_duty_meter.sv
// Directed bench for pulse_duty_meter: waveform phases are driven in whole clk cycles
// and every expected duration, count and flag is worked out by hand.
module tb_pulse_duty_meter;

    logic        clk = 1'b0;
    logic        count_on_rst;
    logic        pulse_in;
    logic        meas_ready;
    logic        meas_valid;
    logic [15:0] on_time;
    logic [15:0] off_time;
    logic [7:0]  meas_count;
    logic        overrun;
    logic        stuck;
    logic        stuck_level;

    int          checks = 0;
    int          errors = 0;
    int          nvalid;
    logic [15:0] last_on;
    logic [15:0] last_off;

    pulse_duty_meter #(
        .CNT_W      (16),
        .SYNC_STAGES(2),
        .TIMEOUT    (50)
    ) dut (
        .clk         (clk),
        .count_on_rst(count_on_rst),
        .pulse_in    (pulse_in),
        .meas_ready  (meas_ready),
        .meas_valid  (meas_valid),
        .on_time     (on_time),
        .off_time    (off_time),
        .meas_count  (meas_count),
        .overrun     (overrun),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold pulse_in at lvl for n cycles, recording any measurement seen
    task automatic drive(input logic lvl, input int n);
        pulse_in = lvl;
        for (int i = 0; i < n; i++) begin
            tick();
            if (meas_valid) begin
                nvalid++;
                last_on  = on_time;
                last_off = off_time;
            end
        end
    endtask

    task automatic period(input int hi, input int lo);
        nvalid = 0;
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_valid"},       32'(meas_valid),  0);
        check({pfx, "_on_time"},     32'(on_time),     0);
        check({pfx, "_off_time"},    32'(off_time),    0);
        check({pfx, "_count"},       32'(meas_count),  0);
        check({pfx, "_overrun"},     32'(overrun),     0);
        check({pfx, "_stuck"},       32'(stuck),       0);
        check({pfx, "_stuck_level"}, 32'(stuck_level), 0);
    endtask

    // High at reset release, 4 low, 10 high, 5 low, then the publishing rise
    task automatic scn1(input string pfx);
        nvalid = 0;
        drive(1'b1, 20);
        drive(1'b0, 4);
        drive(1'b1, 10);
        drive(1'b0, 5);
        check({pfx, "_no_early_publish"}, 32'(nvalid), 0);
        drive(1'b1, 3);
        check({pfx, "_valid_before_lat"}, 32'(meas_valid), 0);
        drive(1'b1, 1);
        check({pfx, "_valid_at_lat"}, 32'(meas_valid), 1);
        check({pfx, "_on"},           32'(on_time),    10);
        check({pfx, "_off"},          32'(off_time),   5);
        check({pfx, "_count"},        32'(meas_count), 1);
    endtask

    initial begin
        count_on_rst = 1'b1;
        pulse_in     = 1'b1;
        meas_ready   = 1'b0;
        nvalid       = 0;
        last_on      = '0;
        last_off     = '0;

        // 1: reset values, initial high blocked, first measurement and latency
        repeat (3) @(posedge clk);
        #1;
        check_reset("t1_rst");
        count_on_rst = 1'b0;
        scn1("t1");

        // 2: steady 7/3 stream with consumer always ready
        meas_ready = 1'b1;
        drive(1'b1, 3);
        drive(1'b0, 3);
        for (int k = 0; k < 4; k++) begin
            period(7, 3);
            check("t2_valid_once", 32'(nvalid),   1);
            check("t2_on",         32'(last_on),  7);
            check("t2_off",        32'(last_off), 3);
        end
        check("t2_overrun", 32'(overrun),    0);
        check("t2_count",   32'(meas_count), 5);

        // 3: two publishes without a read overwrite the data and set overrun
        period(12, 4);
        meas_ready = 1'b0;
        period(6, 6);
        drive(1'b1, 4);
        check("t3_valid",   32'(meas_valid), 1);
        check("t3_on",      32'(on_time),    6);
        check("t3_off",     32'(off_time),   6);
        check("t3_overrun", 32'(overrun),    1);
        check("t3_count",   32'(meas_count), 8);
        meas_ready = 1'b1;
        drive(1'b1, 1);
        meas_ready = 1'b0;
        check("t3_valid_after_read",   32'(meas_valid), 0);
        check("t3_overrun_after_read", 32'(overrun),    1);

        // 4: high phase exceeds TIMEOUT, then recovery on a 5/5 waveform
        drive(1'b1, 60);
        check("t4_stuck",       32'(stuck),       1);
        check("t4_stuck_level", 32'(stuck_level), 1);
        check("t4_no_publish",  32'(meas_count),  8);
        check("t4_valid",       32'(meas_valid),  0);
        drive(1'b0, 5);
        check("t4_stuck_held", 32'(stuck), 1);
        drive(1'b1, 5);
        check("t4_stuck_clear", 32'(stuck), 0);
        drive(1'b0, 5);
        drive(1'b1, 4);
        check("t4_valid_pub", 32'(meas_valid), 1);
        check("t4_on",        32'(on_time),    5);
        check("t4_off",       32'(off_time),   5);
        check("t4_count",     32'(meas_count), 9);

        // 5: asynchronous reset in the middle of a low phase
        drive(1'b1, 1);
        drive(1'b0, 3);
        #3;
        count_on_rst = 1'b1;
        #1;
        check_reset("t5_rst");
        pulse_in = 1'b1;
        tick();
        tick();
        count_on_rst = 1'b0;
        scn1("t5");

        // 6: accept and publish on the same edge, then meas_count wrap
        drive(1'b0, 4);
        drive(1'b1, 3);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        check("t6_valid",   32'(meas_valid), 1);
        check("t6_on",      32'(on_time),    4);
        check("t6_off",     32'(off_time),   4);
        check("t6_overrun", 32'(overrun),    0);
        check("t6_count",   32'(meas_count), 2);
        drive(1'b0, 4);
        meas_ready = 1'b1;
        for (int n = 1; n <= 254; n++) begin
            period(4, 4);
            if (n == 253) check("t6_count_255", 32'(meas_count), 255);
        end
        check("t6_count_wrap", 32'(meas_count), 0);
        check("t6_wrap_on",    32'(last_on),    4);
        check("t6_wrap_off",   32'(last_off),   4);
        check("t6_overrun_end", 32'(overrun),   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_duty_meter.md
Name: pulse_duty_meter

Overview:
- Consumer stage directly downstream of the lm_555 astable timer model.
- Samples the timer's `pulse` output in the system clock domain and measures each complete period's high and low durations in clock cycles.
- Publishes each measurement through a valid/ready handshake.
- Flags a stuck or too-slow timer output.

Parameters:
CNT_W, 16, width of the duration counters and of on_time/off_time
SYNC_STAGES, 2, flip-flop synchronizer depth on pulse_in; legal range 2..4
TIMEOUT, 65535, cycle count at which a phase is declared stuck; must be ≤ 2^CNT_W − 1

Ports:
clk  input  1  system clock, rising-edge active
count_on_rst  input  1  reset count_on_rst, asynchronous, active-high
pulse_in  input  1  asynchronous pulse from the timer
meas_ready  input  1  consumer accepts the measurement on a clk edge where meas_valid=1
meas_valid  output  1  on_time/off_time hold an unread measurement
on_time  output  CNT_W  high-phase length in clk cycles
off_time  output  CNT_W  low-phase length in clk cycles
meas_count  output  8  completed measurements, wraps 255→0
overrun  output  1  sticky: unread measurement was overwritten
stuck  output  1  a phase reached TIMEOUT
stuck_level  output  1  synced level at the moment stuck was set

Behaviour:
- Reset (async assert, released synchronously by clk):
  - All outputs 0.
  - Synchronizer chain and previous-sample register 0.
  - Counters 0; FSM in WAIT_LOW.
  - Reset mid-measurement discards the partial period.
- Synchronizer and edge detect:
  - s = last synchronizer stage; p = s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - Edge-detect latency from pulse_in change is SYNC_STAGES+1 clocks.
- FSM states:
  - WAIT_LOW: go to WAIT_RISE when s=0. Prevents a level already high at reset release from counting as a rise.
  - WAIT_RISE: on rise: on_cnt←1, go to HIGH. Clear stuck on this rise.
  - HIGH: each cycle with s=1, on_cnt←on_cnt+1. On fall: off_cnt←1, go to LOW.
  - LOW: each cycle with s=0, off_cnt←off_cnt+1. On rise: publish, then on_cnt←1, off_cnt←0, go to HIGH.
- Count semantics: a phase lasting N synced cycles yields exactly N.
- Publish (registered; visible the cycle after the rise is detected):
  - on_time←on_cnt, off_time←off_cnt, meas_valid←1, meas_count←meas_count+1.
- Handshake:
  - meas_valid stays high and on_time/off_time stay stable until a clk edge with meas_ready=1, which clears meas_valid.
  - meas_ready while meas_valid=0 has no effect.
- Collision cases:
  - Publish while meas_valid=1 and meas_ready=0: overwrite the data, keep meas_valid=1, set overrun. overrun is cleared only by reset.
  - Publish on the same edge as an accept: load the new data, keep meas_valid=1, do not set overrun.
- Timeout:
  - If on_cnt in HIGH or off_cnt in LOW would exceed TIMEOUT: stuck←1, stuck_level←s, no publish, counters←0.
  - Next state is WAIT_LOW if s=1, otherwise WAIT_RISE.
  - A counter never wraps.
- Phases shorter than SYNC_STAGES may be missed. This is accepted and is not an error.
- A pending unread measurement is unaffected by a timeout.

Test Plan:
1. Reset, then pulse_in stuck high 20 clocks, then 4 low, 10 high, 5 low, rise → WAIT_LOW blocks the initial high; first publish on_time=10, off_time=5, meas_count=1, meas_valid exactly SYNC_STAGES+2 clocks after the final pulse_in rise.
2. Steady 7-high/3-low stream, meas_ready tied 1 → every period publishes 7/3; meas_valid is high 1 cycle per period; overrun stays 0.
3. meas_ready=0 across two periods (12/4, then 6/6) → data reads 6/6, overrun=1, meas_valid=1; assert meas_ready 1 cycle → meas_valid=0, overrun stays 1.
4. TIMEOUT=50, pulse_in held high 60 cycles after a rise → stuck=1, stuck_level=1, no publish; then a 5/5 waveform → stuck cleared on first rise, next publish 5/5.
5. Assert count_on_rst mid-LOW phase (between clk edges) → all outputs 0 immediately, no publish from the partial period; measurement resumes per scenario 1.
6. Accept and new publish on the same edge, 4/4 waveform, meas_ready pulsed on the publish edge → new data loaded, meas_valid stays 1, overrun=0; run 256 periods and check meas_count wraps to 0.
